// File: rtl/spio_uart_pkg.sv
// Shared definitions for the spio UART receiver: parity modes, RX FSM states
// and a constant-evaluable ceiling-log2 helper.
package spio_uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Number of address bits needed to index 'value' items (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/spio_uart_rx_fifo.sv
// Registered output FIFO for received words; ADDR_BITS = 0 degenerates to a
// single holding register. Reports occupancy, free count and a drop pulse.
module spio_uart_rx_fifo #(
    parameter int WIDTH     = 9,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rd_data,
    output logic [ADDR_BITS:0]   occupancy,
    output logic [ADDR_BITS:0]   free_count,
    output logic                 drop_pulse
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_V = (ADDR_BITS+1)'(DEPTH);

    logic [ADDR_BITS:0] count_q, count_d;
    logic               drop_q, drop_d;
    logic               full;
    logic               pop_ok;
    logic               push_ok;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]   wr_en;

    assign full    = (count_q == DEPTH_V);
    assign pop_ok  = pop && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_d = count_q;
        drop_d  = push && full && !pop_ok;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    generate
        if (ADDR_BITS == 0) begin : g_single
            assign wr_en   = push_ok;
            assign rd_data = mem_q[0];
        end else begin : g_ring
            logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
            logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;

            always_comb begin
                wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
                rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
                assign wr_en[gi] = push_ok && (wr_ptr_q == ADDR_BITS'(gi));
            end

            assign rd_data = mem_q[rd_ptr_q];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_q[i] <= push_data;
                end
            end
        end
    end

    assign occupancy  = count_q;
    assign free_count = DEPTH_V - count_q;
    assign drop_pulse = drop_q;

endmodule

// File: rtl/spio_uart_rx_param.sv
// Parametrised UART receiver with 3-sample voting, error reporting and an
// output FIFO with CTS. Parity bit support is built only with SPIO_UART_RX_PARITY_EN.
module spio_uart_rx_param
    import spio_uart_pkg::*;
#(
    parameter int DATA_BITS        = 8,
    parameter int STOP_BITS        = 1,
    parameter int PARITY           = 0,
    parameter int SUBSAMPLES       = 16,
    parameter int BUFFER_ADDR_BITS = 2,
    parameter int CTS_HEADROOM     = 1
) (
    input  logic                 CLK_IN,
    input  logic                 RESET_N_IN,
    input  logic                 SUBSAMPLE_PULSE_IN,
    input  logic                 RX_IN,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 PARITY_ERR_OUT,
    output logic                 VLD_OUT,
    input  logic                 RDY_IN,
    output logic                 CTS_OUT,
    output logic                 FRAMING_ERR_OUT,
    output logic                 BYTE_DROPPED_OUT
);

    localparam int SUB_W = clog2(SUBSAMPLES);
    localparam int BIT_W = clog2(9);
    localparam int HALF  = SUBSAMPLES / 2;
    localparam int FW    = DATA_BITS + 1;
    localparam int OCC_W = BUFFER_ADDR_BITS + 1;

    localparam logic [SUB_W-1:0] CNT_S0   = SUB_W'(HALF - 1);
    localparam logic [SUB_W-1:0] CNT_S1   = SUB_W'(HALF);
    localparam logic [SUB_W-1:0] CNT_DEC  = SUB_W'(HALF + 1);
    localparam logic [SUB_W-1:0] CNT_LAST = SUB_W'(SUBSAMPLES - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [OCC_W-1:0] HEADROOM  = OCC_W'(CTS_HEADROOM);

`ifdef SPIO_UART_RX_PARITY_EN
    localparam bit PAR_ACTIVE = (PARITY != PARITY_NONE);
    localparam bit PAR_ODD    = (PARITY == PARITY_ODD);
`else
    localparam bit PAR_ACTIVE = 1'b0 && (PARITY != PARITY_NONE);
`endif

    rx_state_t            state_q, state_d;
    logic [SUB_W-1:0]     sub_cnt_q, sub_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic                 perr_q, perr_d;
    logic                 stop_err_q, stop_err_d;
    logic                 fe_q, fe_d;
    logic                 cts_q, cts_d;

    logic                 tick_s0, tick_s1, tick_dec;
    logic                 vote;
    logic                 push;
    logic                 pop;
    logic [FW-1:0]        fifo_rd;
    logic [OCC_W-1:0]     fifo_occ;
    logic [OCC_W-1:0]     fifo_free;
    logic                 fifo_drop;

    assign tick_s0  = SUBSAMPLE_PULSE_IN && (sub_cnt_q == CNT_S0);
    assign tick_s1  = SUBSAMPLE_PULSE_IN && (sub_cnt_q == CNT_S1);
    assign tick_dec = SUBSAMPLE_PULSE_IN && (sub_cnt_q == CNT_DEC);
    // Third sample is the live line value on the decision pulse.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & RX_IN) | (samp_q[1] & RX_IN);

    always_comb begin
        state_d    = state_q;
        sub_cnt_d  = SUBSAMPLE_PULSE_IN ? sub_cnt_q + 1'b1 : sub_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        perr_d     = perr_q;
        stop_err_d = stop_err_q;
        fe_d       = 1'b0;
        push       = 1'b0;

        if (tick_s0) samp_d[0] = RX_IN;
        if (tick_s1) samp_d[1] = RX_IN;

        case (state_q)
            ST_WAIT_IDLE: begin
                if (SUBSAMPLE_PULSE_IN) begin
                    if (!RX_IN) begin
                        sub_cnt_d = '0;
                    end else if (sub_cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (SUBSAMPLE_PULSE_IN && !RX_IN) begin
                    sub_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    perr_d     = 1'b0;
                    stop_err_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick_dec) begin
                    state_d = vote ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_dec) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = PAR_ACTIVE ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef SPIO_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_dec) begin
                    perr_d  = PAR_ODD ? ((^shift_q ^ vote) == 1'b0)
                                      : ((^shift_q ^ vote) != 1'b0);
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_dec) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        if (!vote || stop_err_q) begin
                            fe_d      = 1'b1;
                            sub_cnt_d = '0;
                            state_d   = ST_WAIT_IDLE;
                        end else begin
                            push    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_err_d = stop_err_q | !vote;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q    <= ST_WAIT_IDLE;
            sub_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            perr_q     <= 1'b0;
            stop_err_q <= 1'b0;
            fe_q       <= 1'b0;
            cts_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_cnt_q  <= sub_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            perr_q     <= perr_d;
            stop_err_q <= stop_err_d;
            fe_q       <= fe_d;
            cts_q      <= cts_d;
        end
    end

    spio_uart_rx_fifo #(
        .WIDTH     (FW),
        .ADDR_BITS (BUFFER_ADDR_BITS)
    ) u_fifo (
        .clk        (CLK_IN),
        .rst_n      (RESET_N_IN),
        .push       (push),
        .push_data  ({perr_q, shift_q}),
        .pop        (pop),
        .rd_data    (fifo_rd),
        .occupancy  (fifo_occ),
        .free_count (fifo_free),
        .drop_pulse (fifo_drop)
    );

    assign cts_d = (fifo_free > HEADROOM);
    assign pop   = VLD_OUT && RDY_IN;

    assign DATA_OUT         = fifo_rd[DATA_BITS-1:0];
    assign PARITY_ERR_OUT   = fifo_rd[DATA_BITS] & PAR_ACTIVE;
    assign VLD_OUT          = (fifo_occ != '0);
    assign CTS_OUT          = cts_q;
    assign FRAMING_ERR_OUT  = fe_q;
    assign BYTE_DROPPED_OUT = fifo_drop;

endmodule

// File: tb/tb_spio_uart_rx_param.sv
// Scoreboard bench for spio_uart_rx_param: 8-bit, 1 stop, even parity when
// SPIO_UART_RX_PARITY_EN is defined, 16 subsamples, 4-deep FIFO, headroom 1.
module tb_spio_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pulse = 1'b0;
    logic       rx = 1'b1;
    logic       rdy = 1'b0;
    logic [7:0] data;
    logic       perr, vld, cts, fe, drop;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, drop_cnt = 0;
    int exp_fe = 0, exp_drop = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    spio_uart_rx_param #(
        .DATA_BITS        (8),
        .STOP_BITS        (1),
        .PARITY           (1),
        .SUBSAMPLES       (16),
        .BUFFER_ADDR_BITS (2),
        .CTS_HEADROOM     (1)
    ) dut (
        .CLK_IN             (clk),
        .RESET_N_IN         (rst_n),
        .SUBSAMPLE_PULSE_IN (pulse),
        .RX_IN              (rx),
        .DATA_OUT           (data),
        .PARITY_ERR_OUT     (perr),
        .VLD_OUT            (vld),
        .RDY_IN             (rdy),
        .CTS_OUT            (cts),
        .FRAMING_ERR_OUT    (fe),
        .BYTE_DROPPED_OUT   (drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick_pulse();
        repeat (3) @(posedge clk);
        #1 pulse = 1'b1;
        @(posedge clk);
        #1 pulse = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) tick_pulse();
    endtask

    // Start, 8 data bits LSB first, optional parity, stop, one idle bit.
    task automatic send_frame(input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input bit expect_push);
        logic exp_perr;
        exp_perr = 1'b0;
`ifdef SPIO_UART_RX_PARITY_EN
        exp_perr = bad_par;
`endif
        if (bad_stop) exp_fe++;
        else if (expect_push) exp_q.push_back({exp_perr, d});
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef SPIO_UART_RX_PARITY_EN
        send_bit((^d) ^ bad_par, 16);
`endif
        send_bit(!bad_stop, 16);
        send_bit(1'b1, 16);
        $display("frame %02h bad_par=%0d bad_stop=%0d sent", d, bad_par, bad_stop);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fe) fe_cnt++;
            if (drop) drop_cnt++;
            if (vld && rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", {perr, data});
                end else begin
                    check("word", {23'd0, perr, data}, {23'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", vld, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_cts", cts, 1'b0);
        check("rst_perr", perr, 1'b0);
        check("rst_pulses", {fe, drop}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("cts_after_release", cts, 1'b1);

        send_bit(1'b1, 20);
        rdy = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        check("no_fe_yet", fe_cnt, 0);

        send_frame(8'h99, 1'b0, 1'b1, 1'b0);
        check("fe_count", fe_cnt, exp_fe);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);

        send_bit(1'b0, 3);
        send_bit(1'b1, 40);
        check("glitch_vld", vld, 1'b0);
        check("glitch_fe", fe_cnt, exp_fe);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);

        rdy = 1'b0;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(8'h02, 1'b0, 1'b0, 1'b1);
        check("cts_two_words", cts, 1'b1);
        send_frame(8'h03, 1'b0, 1'b0, 1'b1);
        check("cts_three_words", cts, 1'b0);
        check("head_hold", data, 8'h01);
        send_frame(8'h04, 1'b0, 1'b0, 1'b1);
        exp_drop++;
        send_frame(8'h05, 1'b0, 1'b0, 1'b0);
        check("drop_count", drop_cnt, exp_drop);
        check("head_after_drop", data, 8'h01);
        rdy = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
        check("cts_recovered", cts, 1'b1);

        rdy = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        check("pre_reset_vld", vld, 1'b1);
        send_bit(1'b0, 16);
        send_bit(1'b0, 48);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_vld", vld, 1'b0);
        check("midreset_data", data, 8'h00);
        check("midreset_cts", cts, 1'b0);
        check("midreset_perr", perr, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_bit(1'b0, 80);
        send_bit(1'b1, 32);
        check("tail_ignored_vld", vld, 1'b0);
        rdy = 1'b1;
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);

        repeat (20) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_fe", fe_cnt, exp_fe);
        check("final_drop", drop_cnt, exp_drop);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
